// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared types and ratio helpers for the clkgen divider
package clkgen_pkg;

   typedef struct packed {
      logic re;
      logic fe;
   } strobe_t;

   function automatic int calc_period(input int main_hz, input int clk_hz);
      return main_hz / clk_hz;
   endfunction

   function automatic int calc_ph1(input int n);
      return (n + 1) / 2;
   endfunction

   // Clamped to 1 so an illegal ratio still elaborates far enough to be reported.
   function automatic int calc_cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clkgen_cnt.sv
// rtl/clkgen_cnt.sv - modulo-N wrapping counter exposing its next value
module clkgen_cnt #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [W-1:0] cnt_next
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt;

   always_comb begin
      cnt_next = (cnt == LAST) ? '0 : cnt + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/clkgen.sv
// rtl/clkgen.sv - programmable clock divider with registered edge strobes
// Optional checks enabled by defining CLKGEN_ASSERT_EN.
module clkgen
   import clkgen_pkg::*;
#(
   parameter int   MAIN_CLK_HZ = 50_000_000,
   parameter int   CLK_HZ      = 10_000,
   parameter logic CLK_INIT    = 1'b0
) (
   input  logic in_clk,
   input  logic in_rst,
   output logic out_clk,
   output logic out_re,
   output logic out_fe
);

   localparam int N   = calc_period(MAIN_CLK_HZ, CLK_HZ);
   localparam int PH1 = calc_ph1(N);
   localparam int PH2 = N / 2;
   localparam int W   = calc_cnt_width(N);
   localparam logic [W-1:0] PH1_W = W'(PH1);

   logic [W-1:0] cnt_next;
   logic         clk_next;
   strobe_t      strb;
   strobe_t      strb_next;

   clkgen_cnt #(
      .N (N),
      .W (W)
   ) u_cnt (
      .clk      (in_clk),
      .rst_n    (in_rst),
      .cnt_next (cnt_next)
   );

   // Decide from cnt_next so out_clk and the strobes land on the same edge.
   always_comb begin
      clk_next     = (cnt_next < PH1_W) ? CLK_INIT : ~CLK_INIT;
      strb_next.re = clk_next & ~out_clk;
      strb_next.fe = ~clk_next & out_clk;
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         out_clk <= CLK_INIT;
         strb    <= '0;
      end else begin
         out_clk <= clk_next;
         strb    <= strb_next;
      end
   end

   assign out_re = strb.re;
   assign out_fe = strb.fe;

`ifdef CLKGEN_ASSERT_EN
   localparam int HI_LEN = CLK_INIT ? PH1 : PH2;
   localparam int LO_LEN = CLK_INIT ? PH2 : PH1;

   if (N < 2) begin : g_bad_ratio
      $fatal(1, "clkgen: MAIN_CLK_HZ/CLK_HZ = %0d, must be at least 2", N);
   end

   if (MAIN_CLK_HZ % CLK_HZ != 0) begin : g_inexact
      $warning("clkgen: inexact ratio, out_clk runs at %0d Hz", MAIN_CLK_HZ / N);
   end

   a_period: assert property (@(posedge in_clk) disable iff (!in_rst)
      out_re |-> ##N out_re);
   a_high_len: assert property (@(posedge in_clk) disable iff (!in_rst)
      out_re |-> ##HI_LEN out_fe);
   a_low_len: assert property (@(posedge in_clk) disable iff (!in_rst)
      out_fe |-> ##LO_LEN out_re);
   a_mutex: assert property (@(posedge in_clk) disable iff (!in_rst)
      !(out_re && out_fe));
`endif

endmodule

// File: tb/tb_clkgen.sv
// tb/tb_clkgen.sv - directed self-checking bench for clkgen at ratios 5, 4 and 2
module tb_clkgen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic a_clk, a_re, a_fe;
   logic b_clk, b_re, b_fe;
   logic c_clk, c_re, c_fe;

   int checks = 0;
   int errors = 0;
   int b_rises = 0;

   // Expected out_clk after edge k, indexed by k mod N.
   logic pat_a [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic pat_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic pat_c [2] = '{1'b0, 1'b1};

   always #5 clk = ~clk;

   clkgen #(.MAIN_CLK_HZ(500), .CLK_HZ(100), .CLK_INIT(1'b1)) dut_a (
      .in_clk (clk), .in_rst (rst_n), .out_clk (a_clk), .out_re (a_re), .out_fe (a_fe)
   );
   clkgen #(.MAIN_CLK_HZ(400), .CLK_HZ(100), .CLK_INIT(1'b0)) dut_b (
      .in_clk (clk), .in_rst (rst_n), .out_clk (b_clk), .out_re (b_re), .out_fe (b_fe)
   );
   clkgen #(.MAIN_CLK_HZ(200), .CLK_HZ(100), .CLK_INIT(1'b0)) dut_c (
      .in_clk (clk), .in_rst (rst_n), .out_clk (c_clk), .out_re (c_re), .out_fe (c_fe)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_a(input int k, input string ph);
      check($sformatf("%s_a_clk_e%0d", ph, k), a_clk, pat_a[k % 5]);
      check($sformatf("%s_a_re_e%0d", ph, k), a_re, (k > 0) && (k % 5 == 0));
      check($sformatf("%s_a_fe_e%0d", ph, k), a_fe, k % 5 == 3);
   endtask

   task automatic check_c(input int k, input string ph);
      check($sformatf("%s_c_clk_e%0d", ph, k), c_clk, pat_c[k % 2]);
      check($sformatf("%s_c_re_e%0d", ph, k), c_re, k % 2 == 1);
      check($sformatf("%s_c_fe_e%0d", ph, k), c_fe, (k > 0) && (k % 2 == 0));
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_a_clk", a_clk, 1'b1);
      check("rst_b_clk", b_clk, 1'b0);
      check("rst_c_clk", c_clk, 1'b0);
      check("rst_a_strb", a_re | a_fe, 1'b0);
      check("rst_b_strb", b_re | b_fe, 1'b0);
      check("rst_c_strb", c_re | c_fe, 1'b0);

      rst_n = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         @(posedge clk);
         #1;
         check_a(k, "run");
         check_c(k, "run");
         check($sformatf("run_b_clk_e%0d", k), b_clk, pat_b[k % 4]);
         check($sformatf("run_b_re_e%0d", k), b_re, k % 4 == 2);
         check($sformatf("run_b_fe_e%0d", k), b_fe, (k > 0) && (k % 4 == 0));
         if (b_re) b_rises++;
      end
      check_int("b_periods_in_64", b_rises, 16);

      // dut_a is now in its low phase (edge 64, count 4); reset between edges.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_a_clk", a_clk, 1'b1);
      check("async_a_strb", a_re | a_fe, 1'b0);
      check("async_b_clk", b_clk, 1'b0);
      check("async_c_clk", c_clk, 1'b0);
      check("async_c_strb", c_re | c_fe, 1'b0);

      for (int k = 1; k <= 64; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold_a_clk_c%0d", k), a_clk, 1'b1);
         check($sformatf("hold_a_strb_c%0d", k), a_re | a_fe, 1'b0);
         check($sformatf("hold_b_clk_c%0d", k), b_clk, 1'b0);
         check($sformatf("hold_b_strb_c%0d", k), b_re | b_fe, 1'b0);
         check($sformatf("hold_c_clk_c%0d", k), c_clk, 1'b0);
         check($sformatf("hold_c_strb_c%0d", k), c_re | c_fe, 1'b0);
      end

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_a_strb", a_re | a_fe, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         check_a(k, "rel");
         check_c(k, "rel");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clkgen.md
# clkgen

Programmable clock divider. It derives a slow, registered clock `out_clk` from the system clock `in_clk`, with exact period MAIN_CLK_HZ/CLK_HZ input cycles; odd ratios are supported with an asymmetric duty cycle. It also provides single-cycle edge strobes, so downstream logic in the `in_clk` domain can act on slow-clock edges without crossing domains. Typical uses are serial-interface bit clocks, LED/blink timers and slow peripheral strobes.

## Interface
Parameters:
- `MAIN_CLK_HZ`, default 50_000_000: frequency of `in_clk` in Hz.
- `CLK_HZ`, default 10_000: target `out_clk` frequency in Hz.
- `CLK_INIT`, default 1'b0: level of `out_clk` during reset and during the first phase after reset.

Ports (one clock; reset is asynchronous and active-low):
- `in_clk`  in  1: system clock; all logic is clocked on its rising edge.
- `in_rst`  in  1: asynchronous, active-low reset (0 = held in reset).
- `out_clk` out 1: divided clock, driven directly from a flip-flop.
- `out_re`  out 1: one-cycle strobe, high in the cycle in which `out_clk` has just become 1.
- `out_fe`  out 1: one-cycle strobe, high in the cycle in which `out_clk` has just become 0.

## Operation
Derived constants:
- N = MAIN_CLK_HZ / CLK_HZ, using integer division (truncation).
- PH1 = ceil(N/2): length of the first phase, at level `CLK_INIT`.
- PH2 = floor(N/2): length of the second phase, at level `~CLK_INIT`.
- Counter width = $clog2(N).

Legality:
- N ≥ 2 is required, i.e. 2·CLK_HZ ≤ MAIN_CLK_HZ.
- N < 2 is an elaboration error.

Reset (`in_rst`=0):
- Counter `cnt` = 0.
- `out_clk` = `CLK_INIT`.
- `out_re` = `out_fe` = 0.

Each rising edge of `in_clk` while `in_rst`=1:
- cnt_next = (cnt == N-1) ? 0 : cnt+1; `cnt` ← cnt_next.
- `out_clk` ← (cnt_next < PH1) ? `CLK_INIT` : ~`CLK_INIT`.
- `out_re` ← 1 exactly when `out_clk` goes 0→1 on this edge; `out_fe` ← 1 exactly when it goes 1→0.

Boundary conditions:
- Wrap: the counter wraps from N-1 to 0 with no idle cycle, so the period is exactly N cycles.
- Even N: 50 % duty cycle.
- Odd N: the `CLK_INIT` phase is one cycle longer than the other.
- N = 2: `out_clk` toggles on every `in_clk` edge.
- Reset mid-period: output returns to `CLK_INIT` immediately and asynchronously; the next full period starts at the first edge after release.
- Strobes are never high at the same time. No strobe is generated by reset assertion or by reset release itself.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- After reset release, the first `out_clk` transition happens on edge PH1. Transitions then alternate every PH2 and PH1 edges.
- Strobes change on the same edge as the `out_clk` transition they report, with zero added latency.
- Example, MAIN_CLK_HZ=500, CLK_HZ=100, CLK_INIT=1:
  - N=5: high for 3 cycles, low for 2, repeating.
  - `out_clk` first falls on edge 3 and rises on edge 5, 10, 15 and so on.

## Configuration
- `CLKGEN_ASSERT_EN` defined:
  - Elaboration-time `$fatal` if N < 2.
  - Elaboration-time `$warning` if MAIN_CLK_HZ % CLK_HZ ≠ 0, reporting the actual output frequency.
  - Concurrent assertions: period = N; phase lengths = PH1/PH2; `out_re` and `out_fe` mutually exclusive.
- Not defined: no checks or messages. Synthesised logic is identical in both cases.

## Structure
- Package `clkgen_pkg`:
  - Functions `calc_period(main_hz, clk_hz)`, `calc_ph1(n)` and `calc_cnt_width(n)`.
  - Typedef for the strobe pair.
- One sub-module, `clkgen_cnt`: a parameterised modulo-N wrapping counter (async active-low reset) that outputs cnt_next.
- The top level holds the phase compare, the output flop and the edge strobes.

## Test plan
- MAIN=500, CLK=100, CLK_INIT=1, release reset at t0 → `out_clk` pattern 1,1,1,0,0 repeating; `out_re` on edges 5, 10, 15; `out_fe` on edges 3, 8, 13.
- MAIN=400, CLK=100, CLK_INIT=0 → 0,0,1,1 repeating; exactly 16 periods in 64 cycles.
- MAIN=200, CLK=100 → `out_clk` toggles on every edge; strobes alternate every cycle.
- Assert `in_rst`=0 in the middle of the low phase → `out_clk`=CLK_INIT and strobes 0 immediately, without waiting for a clock edge; after release, the first transition comes after PH1 edges.
- `in_rst` held at 0 for 64 cycles → `out_clk` constant at CLK_INIT and no strobes.
- With `CLKGEN_ASSERT_EN`, MAIN=100, CLK=100 → elaboration fails.
